// File: rtl/data_memory_pipe_if.sv
// Request/response bundle between the pipeline and the data memory.
// The master drives requests; the slave (the memory) drives ready and responses.
interface data_memory_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_pipe.sv
// Byte-addressed little-endian data RAM with RV32I load/store sizing, cleared
// word by word after reset, returning responses on a fixed-latency pipeline.
module data_memory_pipe #(
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_pipe_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          f3_ok;
  logic          misaligned;
  logic          req_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic          pipe_v [READ_LAT];
  logic          pipe_e [READ_LAT];
  logic [31:0]   pipe_d [READ_LAT];

  assign bus.req_ready = (state == READY) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign widx          = bus.req_addr[AW+1:2];
  assign lane          = bus.req_addr[1:0];
  assign out_of_range  = |bus.req_addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == INIT)
        clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && clr_idx == AW'(DEPTH - 1))
      state_next = READY;
  end

  // Legality, load extraction and store lane enables all come from the same decode.
  always_comb begin
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    rd_word    = mem[widx];
    rd_byte    = rd_word[7:0];
    rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data  = '0;
    wr_be      = '0;
    wr_data    = bus.req_wdata;

    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase

    case (bus.req_funct3)
      3'b000: begin
        f3_ok     = 1'b1;
        load_data = {{24{rd_byte[7]}}, rd_byte};
        wr_be     = 4'b0001 << lane;
        wr_data   = {4{bus.req_wdata[7:0]}};
      end
      3'b001: begin
        f3_ok      = 1'b1;
        misaligned = lane[0];
        load_data  = {{16{rd_half[15]}}, rd_half};
        wr_be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_data    = {2{bus.req_wdata[15:0]}};
      end
      3'b010: begin
        f3_ok      = 1'b1;
        misaligned = |lane;
        load_data  = rd_word;
        wr_be      = 4'b1111;
      end
      3'b100: begin
        f3_ok     = !bus.req_we;
        load_data = {24'h0, rd_byte};
      end
      3'b101: begin
        f3_ok      = !bus.req_we;
        misaligned = lane[0];
        load_data  = {16'h0, rd_half};
      end
      default: f3_ok = 1'b0;
    endcase

    req_err = !f3_ok || misaligned || out_of_range;
    if (req_err || bus.req_we)
      load_data = '0;
    if (req_err || !bus.req_we)
      wr_be = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[clr_idx] <= '0;
      end else if (accept) begin
        for (int b = 0; b < 4; b++)
          if (wr_be[b])
            mem[widx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Data and error registers only load behind a valid entry so the last response holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= accept;
      if (accept) begin
        pipe_e[0] <= req_err;
        pipe_d[0] <= load_data;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_e[i] <= pipe_e[i-1];
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign bus.rsp_valid = pipe_v[READ_LAT-1] && !reset;
  assign bus.rsp_err   = pipe_e[READ_LAT-1] && !reset;
  assign bus.rsp_rdata = reset ? '0 : pipe_d[READ_LAT-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench: an 8-word single-latency memory for sizing/errors and an
// 8-word three-cycle-latency memory for ordering and reset flushing.
module tb_data_memory_pipe;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic reset1;
  logic reset3;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  data_memory_pipe_if bus1 ();
  data_memory_pipe_if bus3 ();

  data_memory_pipe #(.DEPTH(8), .READ_LAT(1)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  data_memory_pipe #(.DEPTH(8), .READ_LAT(3)) dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (bus3)
  );

  // One request on the latency-1 memory, called at a negedge; returns {valid, err, rdata}.
  task automatic xact1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [33:0] rsp);
    bus1.req_valid  = 1'b1;
    bus1.req_we     = we;
    bus1.req_funct3 = f3;
    bus1.req_addr   = addr;
    bus1.req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    rsp = {bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata};
  endtask

  task automatic test_reset();
    int cycles;
    logic [33:0] r;
    reset1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata} !== 35'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b err=%b data=%h, want all zero",
               bus1.req_ready, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata);
    end
    reset1 = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end while (!bus1.req_ready && cycles < 20);
    compared++;
    if (cycles !== 8 || bus1.req_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL init_ready_edge: got edge %0d ready=%b, want edge 8 ready=1",
               cycles, bus1.req_ready);
    end
    xact1(1'b0, 3'b010, 32'h1C, 32'h0, r);
    compared++;
    if (r !== {1'b1, 1'b0, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL lw_0x1c_after_init: got %h, want %h", r, {1'b1, 1'b0, 32'h0});
    end
  endtask

  task automatic test_store_load();
    vec_t v[6];
    logic [33:0] r;
    v = '{'{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000},
          '{1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFFDE},
          '{1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h000000DE},
          '{1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFFDEAD},
          '{1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h0000DEAD},
          '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF}};
    for (int i = 0; i < 6; i++) begin
      xact1(v[i].we, v[i].f3, v[i].addr, v[i].wdata, r);
      compared++;
      if (r !== {1'b1, v[i].err, v[i].data}) begin
        mismatched++;
        $display("[TB] FAIL store_load[%0d]: got %h, want %h", i, r, {1'b1, v[i].err, v[i].data});
      end
    end
  endtask

  task automatic test_subword_store();
    vec_t v[6];
    logic [33:0] r;
    v = '{'{1'b1, 3'b001, 32'h12, 32'hFFFF1234, 1'b0, 32'h00000000},
          '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h1234BEEF},
          '{1'b1, 3'b000, 32'h10, 32'hAAAAAA77, 1'b0, 32'h00000000},
          '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h1234BE77},
          '{1'b0, 3'b000, 32'h11, 32'h0,        1'b0, 32'hFFFFFFBE},
          '{1'b0, 3'b100, 32'h12, 32'h0,        1'b0, 32'h00000034}};
    for (int i = 0; i < 6; i++) begin
      xact1(v[i].we, v[i].f3, v[i].addr, v[i].wdata, r);
      compared++;
      if (r !== {1'b1, v[i].err, v[i].data}) begin
        mismatched++;
        $display("[TB] FAIL subword[%0d]: got %h, want %h", i, r, {1'b1, v[i].err, v[i].data});
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[8];
    logic [33:0] r;
    v = '{'{1'b0, 3'b010, 32'h11, 32'h0,        1'b1, 32'h0},
          '{1'b1, 3'b010, 32'h12, 32'hCAFEF00D, 1'b1, 32'h0},
          '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h1234BE77},
          '{1'b0, 3'b001, 32'h13, 32'h0,        1'b1, 32'h0},
          '{1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0},
          '{1'b1, 3'b100, 32'h10, 32'h55555555, 1'b1, 32'h0},
          '{1'b1, 3'b111, 32'h10, 32'h66666666, 1'b1, 32'h0},
          '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h1234BE77}};
    for (int i = 0; i < 8; i++) begin
      xact1(v[i].we, v[i].f3, v[i].addr, v[i].wdata, r);
      compared++;
      if (r !== {1'b1, v[i].err, v[i].data}) begin
        mismatched++;
        $display("[TB] FAIL errors[%0d]: got %h, want %h", i, r, {1'b1, v[i].err, v[i].data});
      end
    end
  endtask

  task automatic test_range();
    vec_t v[5];
    logic [33:0] r;
    v = '{'{1'b0, 3'b010, 32'h20,       32'h0,        1'b1, 32'h0},
          '{1'b1, 3'b010, 32'h20,       32'hDEADBEEF, 1'b1, 32'h0},
          '{1'b0, 3'b010, 32'h00,       32'h0,        1'b0, 32'h0},
          '{1'b0, 3'b000, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0},
          '{1'b1, 3'b000, 32'h40,       32'h000000AB, 1'b1, 32'h0}};
    for (int i = 0; i < 5; i++) begin
      xact1(v[i].we, v[i].f3, v[i].addr, v[i].wdata, r);
      compared++;
      if (r !== {1'b1, v[i].err, v[i].data}) begin
        mismatched++;
        $display("[TB] FAIL range[%0d]: got %h, want %h", i, r, {1'b1, v[i].err, v[i].data});
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t        s[6];
    logic        sv[6];
    logic [33:0] r;
    s = '{'{1'b1, 3'b010, 32'h04, 32'h11223344, 1'b0, 32'h00000000},
          '{1'b0, 3'b010, 32'h04, 32'h0,        1'b0, 32'h11223344},
          '{1'b0, 3'b010, 32'h05, 32'h0,        1'b1, 32'h00000000},
          '{1'b0, 3'b010, 32'h00, 32'h0,        1'b1, 32'h00000000},
          '{1'b0, 3'b101, 32'h06, 32'h0,        1'b0, 32'h00001122},
          '{1'b0, 3'b010, 32'h00, 32'h0,        1'b0, 32'h00001122}};
    sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      bus1.req_valid  = sv[i];
      bus1.req_we     = s[i].we;
      bus1.req_funct3 = s[i].f3;
      bus1.req_addr   = s[i].addr;
      bus1.req_wdata  = s[i].wdata;
      @(posedge clk);
      @(negedge clk);
      r = {bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata};
      compared++;
      if (r !== {sv[i], s[i].err, s[i].data}) begin
        mismatched++;
        $display("[TB] FAIL back_to_back[%0d]: got %h, want %h", i, r, {sv[i], s[i].err, s[i].data});
      end
    end
    bus1.req_valid = 1'b0;
  endtask

  task automatic test_latency3();
    int          cycles;
    logic        we[8];
    logic [31:0] addr[8];
    logic [31:0] wdata[8];
    logic [31:0] exp_d[8];
    logic [33:0] expv;
    logic [33:0] r;
    we    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    addr  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'h8, 32'h4, 32'h0};
    wdata = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0, 0};
    exp_d = '{0, 0, 0, 0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    reset3 = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end while (!bus3.req_ready && cycles < 20);
    compared++;
    if (cycles !== 8) begin
      mismatched++;
      $display("[TB] FAIL lat3_init_ready_edge: got edge %0d, want edge 8", cycles);
    end
    expv = '0;
    for (int j = 0; j < 12; j++) begin
      bus3.req_valid  = (j < 8);
      bus3.req_we     = (j < 8) ? we[j] : 1'b0;
      bus3.req_funct3 = 3'b010;
      bus3.req_addr   = (j < 8) ? addr[j] : 32'h0;
      bus3.req_wdata  = (j < 8) ? wdata[j] : 32'h0;
      @(posedge clk);
      @(negedge clk);
      if (j >= 2 && j < 10)
        expv = {1'b1, 1'b0, exp_d[j-2]};
      else
        expv[33] = 1'b0;
      r = {bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata};
      compared++;
      if (r !== expv) begin
        mismatched++;
        $display("[TB] FAIL lat3_order[%0d]: got %h, want %h", j, r, expv);
      end
    end
    bus3.req_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    int          cycles;
    logic        seen_valid;
    logic [33:0] r;
    logic [33:0] expv;
    bus3.req_we     = 1'b0;
    bus3.req_funct3 = 3'b010;
    for (int j = 0; j < 2; j++) begin
      bus3.req_valid = 1'b1;
      bus3.req_addr  = 32'(4 * j) + 32'h4;
      @(posedge clk);
      @(negedge clk);
    end
    bus3.req_valid = 1'b0;
    reset3 = 1'b1;
    seen_valid = 1'b0;
    repeat (2) begin
      seen_valid = seen_valid | bus3.rsp_valid;
      @(posedge clk);
      @(negedge clk);
    end
    reset3 = 1'b0;
    cycles = 0;
    do begin
      seen_valid = seen_valid | bus3.rsp_valid;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end while (!bus3.req_ready && cycles < 20);
    compared++;
    if (seen_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flush: got rsp_valid=1 during reset/init, want 0");
    end
    compared++;
    if (cycles !== 8) begin
      mismatched++;
      $display("[TB] FAIL reinit_ready_edge: got edge %0d, want edge 8", cycles);
    end
    bus3.req_valid = 1'b1;
    bus3.req_addr  = 32'h4;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      bus3.req_valid = 1'b0;
      expv = (j == 2) ? {1'b1, 1'b0, 32'h0} : 34'h0;
      r = {bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata};
      compared++;
      if (r !== expv) begin
        mismatched++;
        $display("[TB] FAIL reinit_read[%0d]: got %h, want %h", j, r, expv);
      end
    end
  endtask

  initial begin
    reset1 = 1'b1;
    reset3 = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'b0;
    bus1.req_addr  = 32'h0; bus1.req_wdata = 32'h0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_funct3 = 3'b0;
    bus3.req_addr  = 32'h0; bus3.req_wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_store_load();
    test_subword_store();
    test_errors();
    test_range();
    test_back_to_back();
    test_latency3();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
